// File: rtl/lc3b_types.sv
// Shared types for the LC-3b cache controller: FSM state encoding and pmem address selects.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    RETRY     = 2'd3
  } cache_ctrl_state_t;

  localparam logic [1:0] PMEM_SEL_CPU  = 2'd0;
  localparam logic [1:0] PMEM_SEL_WAY0 = 2'd1;
  localparam logic [1:0] PMEM_SEL_WAY1 = 2'd2;

endpackage

// File: rtl/cache_perf_ctr.sv
// Saturating hit/miss counters; only built when CACHE_CTRL_PERF_EN is defined.
module cache_perf_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss_evt,
  input  logic        i_mem_resp,
  output logic [15:0] o_hit_count,
  output logic [15:0] o_miss_count
);

  logic        r_miss_pending;
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  // The completion that follows an allocate belongs to the miss, not a new hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_miss_pending <= 1'b0;
      r_hit_count    <= 16'd0;
      r_miss_count   <= 16'd0;
    end else begin
      if (i_miss_evt) begin
        r_miss_pending <= 1'b1;
        if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
      end else if (i_mem_resp) begin
        r_miss_pending <= 1'b0;
        if (!r_miss_pending && r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
      end
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;

endmodule

// File: rtl/cache_control.sv
// Two-way write-back cache controller FSM with pmem watchdog.
// Optional perf counters are enabled by defining CACHE_CTRL_PERF_EN.
module cache_control
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              mem_resp,
  input  logic [1:0]        hit,
  input  logic [1:0]        dirty,
  input  logic              lru,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic              pmem_resp,
  output logic [1:0]        pmem_addr_sel,
  output logic              data_sel,
  output logic [1:0]        line_load,
  output logic [1:0]        data_load,
  output logic [1:0]        dirty_load,
  output logic              dirty_in,
  output logic              lru_load,
  output logic              lru_in,
  output cache_ctrl_state_t dbg_state,
  output logic              pmem_timeout
`ifdef CACHE_CTRL_PERF_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int WD_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  cache_ctrl_state_t r_state, r_origin, w_next;
  logic              r_victim;
  logic [WD_W-1:0]   r_wd;
  logic              w_req;
  logic              w_hit_way;
  logic [1:0]        w_hit_oh;
  logic [1:0]        w_victim_oh;
  logic              w_expired;

  assign w_req       = mem_read | mem_write;
  assign w_hit_way   = ~hit[0];
  assign w_hit_oh    = w_hit_way ? 2'b10 : 2'b01;
  assign w_victim_oh = r_victim ? 2'b10 : 2'b01;
  assign w_expired   = (TIMEOUT_CYCLES != 0) && (r_wd == WD_W'(TIMEOUT_CYCLES)) && !pmem_resp;
  assign dbg_state   = r_state;

  // Handshake: mem_read/mem_write are held by the CPU until the single-cycle mem_resp.
  always_comb begin
    w_next        = r_state;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = PMEM_SEL_CPU;
    data_sel      = 1'b0;
    line_load     = 2'b00;
    data_load     = 2'b00;
    dirty_load    = 2'b00;
    dirty_in      = 1'b0;
    lru_load      = 1'b0;
    lru_in        = 1'b0;
    pmem_timeout  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (hit != 2'b00) begin
            mem_resp = 1'b1;
            lru_load = 1'b1;
            lru_in   = ~w_hit_way;
            if (mem_write) begin
              data_load  = w_hit_oh;
              dirty_load = w_hit_oh;
              dirty_in   = 1'b1;
            end
          end else begin
            w_next = dirty[lru] ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = r_victim ? PMEM_SEL_WAY1 : PMEM_SEL_WAY0;
        if (pmem_resp) begin
          w_next = ALLOCATE;
        end else if (w_expired) begin
          pmem_timeout = 1'b1;
          w_next       = RETRY;
        end
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          line_load  = w_victim_oh;
          data_load  = w_victim_oh;
          dirty_load = w_victim_oh;
          data_sel   = 1'b1;
          w_next     = IDLE;
        end else if (w_expired) begin
          pmem_timeout = 1'b1;
          w_next       = RETRY;
        end
      end
      RETRY: begin
        w_next = r_origin;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_origin <= IDLE;
      r_victim <= 1'b0;
      r_wd     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next != IDLE) r_victim <= lru;
      if (w_next == RETRY) r_origin <= r_state;
      // Watchdog restarts on every entry to a pmem state, including re-entry after RETRY.
      if (w_next != r_state && (w_next == WRITEBACK || w_next == ALLOCATE)) begin
        r_wd <= '0;
      end else if ((r_state == WRITEBACK || r_state == ALLOCATE) && !pmem_resp && r_wd != '1) begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

`ifdef CACHE_CTRL_PERF_EN
  logic w_miss_evt;
  assign w_miss_evt = (r_state == IDLE) && (w_next != IDLE);

  cache_perf_ctr u_perf (
    .clk          (clk),
    .rst          (rst),
    .i_miss_evt   (w_miss_evt),
    .i_mem_resp   (mem_resp),
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count)
  );
`endif

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: directed scenarios plus random accesses driven from a 2-way set model.
module tb_cache_control;
  import lc3b_types::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_read, mem_write, mem_resp;
  logic [1:0]        hit, dirty;
  logic              lru;
  logic              pmem_read, pmem_write, pmem_resp;
  logic [1:0]        pmem_addr_sel;
  logic              data_sel;
  logic [1:0]        line_load, data_load, dirty_load;
  logic              dirty_in, lru_load, lru_in, pmem_timeout;
  cache_ctrl_state_t dbg_state;
`ifdef CACHE_CTRL_PERF_EN
  logic [15:0]       hit_count, miss_count;
`endif

  int total = 0;
  int bad   = 0;

  // Model of one set: tags, valid, dirty and LRU.
  logic [1:0] mt [2];
  logic [1:0] mv, md;
  logic       ml;

  cache_control #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit(hit), .dirty(dirty), .lru(lru), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .pmem_addr_sel(pmem_addr_sel), .data_sel(data_sel),
    .line_load(line_load), .data_load(data_load), .dirty_load(dirty_load), .dirty_in(dirty_in),
    .lru_load(lru_load), .lru_in(lru_in), .dbg_state(dbg_state), .pmem_timeout(pmem_timeout)
`ifdef CACHE_CTRL_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] outs();
    return {mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel, line_load, data_load,
            dirty_load, dirty_in, lru_load, lru_in, pmem_timeout};
  endfunction

  function automatic logic [15:0] ov(input logic resp, input logic rd, input logic wr,
                                     input logic [1:0] sel, input logic dsel,
                                     input logic [1:0] ll, input logic [1:0] dl,
                                     input logic [1:0] dyl, input logic din,
                                     input logic ld, input logic lin, input logic to);
    return {resp, rd, wr, sel, dsel, ll, dl, dyl, din, ld, lin, to};
  endfunction

  // A hit completes at once; LRU points at the other way, writes also mark the way dirty.
  function automatic logic [15:0] hit_exp(input logic w, input logic [1:0] oh);
    return ov(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, w ? oh : 2'b00, w ? oh : 2'b00, w,
              1'b1, oh[0], 1'b0);
  endfunction

  task automatic access(input string nm, input logic rd, input logic wr, input logic [1:0] h,
                        input logic [1:0] d, input logic l, input int wb_lat, input int al_lat,
                        input bit wd);
    logic [1:0] oh;
    oh = l ? 2'b10 : 2'b01;
    mem_read = rd; mem_write = wr; hit = h; dirty = d; lru = l; pmem_resp = 1'b0;
    @(negedge clk);
    if (h != 2'b00) begin
      chk($sformatf("%s_hit", nm), outs(), hit_exp(wr, h[0] ? 2'b01 : 2'b10));
      tick();
      mem_read = 1'b0; mem_write = 1'b0;
      return;
    end
    chk($sformatf("%s_miss", nm), outs(), 16'h0);
    tick();
    if (wd) begin mem_read = 1'b0; mem_write = 1'b0; end
    if (d[l]) begin
      for (int c = 0; c <= wb_lat; c++) begin
        pmem_resp = (c == wb_lat);
        @(negedge clk);
        chk($sformatf("%s_wb%0d", nm, c), outs(),
            ov(1'b0, 1'b0, 1'b1, l ? 2'd2 : 2'd1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
      end
    end
    for (int c = 0; c <= al_lat; c++) begin
      pmem_resp = (c == al_lat);
      @(negedge clk);
      if (c == al_lat)
        chk($sformatf("%s_alfill", nm), outs(),
            ov(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, oh, oh, oh, 1'b0, 1'b0, 1'b0, 1'b0));
      else
        chk($sformatf("%s_al%0d", nm, c), outs(),
            ov(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
      tick();
    end
    pmem_resp = 1'b0; hit = oh;
    @(negedge clk);
    chk($sformatf("%s_done", nm), outs(), wd ? 16'h0 : hit_exp(wr, oh));
    tick();
    mem_read = 1'b0; mem_write = 1'b0; hit = 2'b00;
  endtask

  initial begin
    logic [1:0] h;
    logic [1:0] t;
    logic       way, rd, wr;
    int         op;
    bit         wd;

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; hit = 2'b00; dirty = 2'b00;
    lru = 1'b0; pmem_resp = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("reset_outs", outs(), 16'h0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    tick();
    rst = 1'b0;
    tick();

    // Write miss with dirty victim way0: writeback, allocate, then the write hits.
    access("wmiss", 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 2, 1, 1'b0);
`ifdef CACHE_CTRL_PERF_EN
    chk("perf_miss", 32'(miss_count), 32'd1);
    chk("perf_hit", 32'(hit_count), 32'd0);
`endif

    access("rhit", 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 0, 0, 1'b0);
    access("whit", 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 0, 0, 1'b0);
    access("bothhit", 1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 0, 0, 1'b0);
    access("rmiss", 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 0, 3, 1'b0);
    access("wdraw", 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 1, 2, 1'b1);

    // Watchdog: no pmem_resp for five ALLOCATE cycles, one RETRY cycle, then re-entry.
    mem_read = 1'b1; hit = 2'b00; dirty = 2'b00; lru = 1'b0;
    @(negedge clk);
    chk("to_miss", outs(), 16'h0);
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("to_al%0d", c), outs(),
          ov(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, c == 4));
      tick();
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    chk("to_retry_outs", outs(), 16'h0);
    chk("to_retry_state", 32'(dbg_state), 32'(RETRY));
    tick();
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("to_realloc", outs(),
        ov(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    pmem_resp = 1'b1;
    @(negedge clk);
    chk("to_fill", outs(),
        ov(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    pmem_resp = 1'b0; hit = 2'b01;
    @(negedge clk);
    chk("to_hit", outs(), hit_exp(1'b0, 2'b01));
    tick();
    mem_read = 1'b0; hit = 2'b00;

    // Reset in the middle of a writeback.
    mem_write = 1'b1; dirty = 2'b01; lru = 1'b0;
    @(negedge clk);
    chk("rs_miss", outs(), 16'h0);
    tick();
    @(negedge clk);
    chk("rs_wb", outs(),
        ov(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b1; mem_write = 1'b0; dirty = 2'b00;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rs_outs", outs(), 16'h0);
    chk("rs_state", 32'(dbg_state), 32'(IDLE));
    tick();
    access("rs_rhit", 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 0, 0, 1'b0);

    // Random accesses against the set model.
    mt[0] = 2'd0; mt[1] = 2'd0; mv = 2'b00; md = 2'b00; ml = 1'b0;
    for (int n = 0; n < 60; n++) begin
      t  = 2'($urandom_range(0, 3));
      op = $urandom_range(0, 2);
      wd = ($urandom_range(0, 7) == 0);
      rd = (op != 1);
      wr = (op != 0);
      h  = {mv[1] && mt[1] == t, mv[0] && mt[0] == t};
      access($sformatf("rnd%0d", n), rd, wr, h, md, ml,
             $urandom_range(0, 3), $urandom_range(0, 3), wd);
      if (h != 2'b00) begin
        way = h[0] ? 1'b0 : 1'b1;
        ml  = ~way;
        if (wr) md[way] = 1'b1;
      end else begin
        way     = ml;
        mt[way] = t;
        mv[way] = 1'b1;
        md[way] = 1'b0;
        if (!wd) begin
          ml = ~way;
          if (wr) md[way] = 1'b1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, pmem watchdog limit in cycles; 0 disables the watchdog.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk, input, 1, rising-edge clock.
REQ-003 SHALL have: rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have: mem_read, mem_write, input, 1 each, CPU request, held until mem_resp.
REQ-005 SHALL have: mem_resp, output, 1, one-cycle request completion.
REQ-006 SHALL have: hit, input, 2, per-way tag match AND valid from the datapath.
REQ-007 SHALL have: dirty, input, 2, per-way dirty bits at the current index.
REQ-008 SHALL have: lru, input, 1, least-recently-used way at the current index.
REQ-009 SHALL have: pmem_read, pmem_write, output, 1 each, physical memory strobes.
REQ-010 SHALL have: pmem_resp, input, 1, physical memory completion.
REQ-011 SHALL have: pmem_addr_sel, output, 2, 0 = CPU address, 1 = way0 tag+index, 2 = way1 tag+index.
REQ-012 SHALL have: data_sel, output, 1, 0 = CPU write merge, 1 = pmem line.
REQ-013 SHALL have: line_load, output, 2, per-way tag and valid write enable.
REQ-014 SHALL have: data_load, output, 2, per-way data array write enable.
REQ-015 SHALL have: dirty_load, output, 2, per-way dirty write enable; and dirty_in, output, 1, dirty value written.
REQ-016 SHALL have: lru_load, output, 1, and lru_in, output, 1, LRU update.
REQ-017 SHALL have: pmem_timeout, output, 1, one-cycle watchdog expiry pulse.

Function
REQ-018 SHALL implement FSM states IDLE, WRITEBACK, ALLOCATE, RETRY, with all outputs Moore/Mealy-decoded; every output not listed for a state SHALL be 0.
REQ-019 In IDLE with a request and hit != 0: SHALL assert mem_resp the same cycle, lru_load = 1, lru_in = the non-hit way, and remain in IDLE.
REQ-020 In an IDLE write hit: SHALL additionally assert data_load and dirty_load for the hit way, dirty_in = 1, data_sel = 0.
REQ-021 In IDLE on a miss: SHALL latch victim = lru into a register, then go to WRITEBACK if dirty[victim] = 1, otherwise to ALLOCATE.
REQ-022 WRITEBACK: pmem_write = 1, pmem_addr_sel = 1 + victim; on pmem_resp SHALL go to ALLOCATE.
REQ-023 ALLOCATE: pmem_read = 1, pmem_addr_sel = 0; on pmem_resp SHALL pulse line_load[victim], data_load[victim] (data_sel = 1) and dirty_load[victim] (dirty_in = 0), then go to IDLE, where the retried access hits.
REQ-024 When mem_read and mem_write are both 1, SHALL treat the request as a write.
REQ-025 Requests withdrawn mid-miss SHALL NOT abort the pmem transaction; the FSM SHALL finish it and return to IDLE without mem_resp.
REQ-026 Watchdog: an 8+-bit counter SHALL clear on entry to WRITEBACK/ALLOCATE and count each cycle without pmem_resp.
REQ-027 When the watchdog count reaches TIMEOUT_CYCLES, SHALL pulse pmem_timeout and go to RETRY for exactly one cycle with all strobes 0, then re-enter the originating state.
REQ-028 pmem_resp SHALL be ignored in IDLE and RETRY.

Reset
REQ-029 On rst: state = IDLE, victim = 0, watchdog = 0, counters = 0; all outputs 0 the cycle after rst is sampled, including when reset arrives mid-miss.

Configuration
REQ-030 With CACHE_CTRL_PERF_EN defined: SHALL add outputs hit_count[15:0] and miss_count[15:0], both saturating at 0xFFFF.
REQ-031 With CACHE_CTRL_PERF_EN defined: a miss SHALL count once, on leaving IDLE; the post-allocate hit of the same request SHALL NOT count as a hit (miss_pending flag, cleared on mem_resp).
REQ-032 Without CACHE_CTRL_PERF_EN: the counter ports and logic SHALL be absent.

Structure
REQ-033 The cache_ctrl_state_t enum and the constants PMEM_SEL_CPU/WAY0/WAY1 SHALL reside in lc3b_types.
REQ-034 The counters SHALL be the sub-module cache_perf_ctr, instantiated under the macro.

Verification
REQ-035 The bench SHALL cover: read, hit = 01 -> mem_resp in the same cycle, lru_load = 1, lru_in = 1.
REQ-036 The bench SHALL cover: write, hit = 10 -> data_load = 10, dirty_load = 10, dirty_in = 1, lru_in = 0.
REQ-037 The bench SHALL cover: read miss, lru = 1, dirty = 00, pmem_resp after 3 cycles -> pmem_read for 4 cycles; line_load = 10; mem_resp 1 cycle later.
REQ-038 The bench SHALL cover: write miss, lru = 0, dirty = 01 -> WRITEBACK with pmem_addr_sel = 1, then ALLOCATE, then write hit; miss_count = 1, hit_count = 0.
REQ-039 The bench SHALL cover: TIMEOUT_CYCLES = 4, no pmem_resp -> pmem_timeout on the 5th ALLOCATE cycle, 1 idle cycle, then pmem_read reasserted.
REQ-040 The bench SHALL cover: rst during WRITEBACK -> pmem_write = 0 next cycle; state IDLE; a new read hit then completes normally.
